// File: rtl/ahb_sram_ctrl_if.sv
// ahb_sram_ctrl_if: AHB-Lite slave bus plus single-port SRAM macro port.
interface ahb_sram_ctrl_if #(parameter int AW = 12);
    logic          HSEL;
    logic [31:0]   HADDR;
    logic [1:0]    HTRANS;
    logic          HWRITE;
    logic [2:0]    HSIZE;
    logic [31:0]   HWDATA;
    logic          HREADY;
    logic          HREADYOUT;
    logic          HRESP;
    logic [31:0]   HRDATA;
    logic [31:0]   SRAMRDATA;
    logic [3:0]    SRAMWEN;
    logic [31:0]   SRAMWDATA;
    logic          SRAMCS0;
    logic [AW-1:0] SRAMADDR;
    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY, SRAMRDATA,
        output HREADYOUT, HRESP, HRDATA, SRAMWEN, SRAMWDATA, SRAMCS0, SRAMADDR
    );
    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY, SRAMRDATA,
        input  HREADYOUT, HRESP, HRDATA, SRAMWEN, SRAMWDATA, SRAMCS0, SRAMADDR
    );
endinterface

// File: rtl/ahb_sram_ctrl.sv
// ahb_sram_ctrl: zero-wait AHB-Lite to SRAM bridge with one-entry write buffer and read forwarding.
// Optional AHB_SRAM_ERR_EN: out-of-range word indices get a two-cycle ERROR response.
module ahb_sram_ctrl #(
    parameter int AW    = 12,
    parameter int DEPTH = 3072
) (
    input logic             HCLK,
    input logic             HRESETn,
    ahb_sram_ctrl_if.slave  bus
);
    logic          accept, in_range, rd_ap, cs;
    logic          dp_rd, dp_wr, buf_valid;
    logic [AW-1:0] idx, dp_addr, buf_addr;
    logic [3:0]    lane, dp_wen, buf_wen, hit;
    logic [31:0]   buf_data, mask;
    logic          unused;

    assign unused = ^{bus.HTRANS[0], bus.HADDR[31:AW+2]};
    assign idx    = bus.HADDR[AW+1:2];
    assign accept = bus.HSEL & bus.HREADY & bus.HTRANS[1];
    assign rd_ap  = accept & ~bus.HWRITE & in_range;
    assign lane   = bus.HSIZE == 3'd0 ? 4'b0001 << bus.HADDR[1:0] :
                    bus.HSIZE == 3'd1 ? (bus.HADDR[1] ? 4'b1100 : 4'b0011) : 4'b1111;

`ifdef AHB_SRAM_ERR_EN
    localparam logic [1:0]  ERR_IDLE  = 2'd0;
    localparam logic [1:0]  ERR_FIRST = 2'd1;
    localparam logic [1:0]  ERR_LAST  = 2'd2;
    localparam logic [AW:0] LIM       = (AW+1)'(DEPTH);
    logic [1:0] err_st;
    assign in_range = {1'b0, idx} < LIM;
    always_ff @(posedge HCLK)
        if (!HRESETn) err_st <= ERR_IDLE;
        else err_st <= (accept & ~in_range) ? ERR_FIRST : err_st == ERR_FIRST ? ERR_LAST : ERR_IDLE;
    assign bus.HREADYOUT = ~HRESETn | (err_st != ERR_FIRST);
    assign bus.HRESP     = HRESETn & (err_st != ERR_IDLE);
`else
    assign in_range      = 1'b1;
    assign bus.HREADYOUT = 1'b1;
    assign bus.HRESP     = 1'b0;
`endif

    always_ff @(posedge HCLK)
        if (!HRESETn) begin
            dp_rd     <= 1'b0;
            dp_wr     <= 1'b0;
            dp_addr   <= '0;
            dp_wen    <= '0;
            buf_valid <= 1'b0;
            buf_addr  <= '0;
            buf_wen   <= '0;
            buf_data  <= '0;
        end else begin
            dp_rd <= rd_ap;
            dp_wr <= accept & bus.HWRITE & in_range;
            if (accept) begin
                dp_addr <= idx;
                dp_wen  <= lane;
            end
            // a write data phase losing the port to a read is parked; it drains on the next free cycle
            if (dp_wr & rd_ap) begin
                buf_valid <= 1'b1;
                buf_addr  <= dp_addr;
                buf_wen   <= dp_wen;
                buf_data  <= bus.HWDATA;
            end else if (~rd_ap & ~dp_wr)
                buf_valid <= 1'b0;
        end

    assign cs            = HRESETn & (rd_ap | dp_wr | buf_valid);
    assign bus.SRAMCS0   = cs;
    assign bus.SRAMADDR  = !cs ? '0 : rd_ap ? idx : dp_wr ? dp_addr : buf_addr;
    assign bus.SRAMWEN   = (!cs || rd_ap) ? 4'b0000 : dp_wr ? dp_wen : buf_wen;
    assign bus.SRAMWDATA = (!cs || rd_ap) ? 32'h0 : dp_wr ? bus.HWDATA : buf_data;

    assign hit        = (dp_rd && buf_valid && buf_addr == dp_addr) ? buf_wen : 4'b0000;
    assign mask       = {{8{hit[3]}}, {8{hit[2]}}, {8{hit[1]}}, {8{hit[0]}}};
    assign bus.HRDATA = (buf_data & mask) | (bus.SRAMRDATA & ~mask);
endmodule

// File: tb/tb_ahb_sram_ctrl.sv
// tb_ahb_sram_ctrl: directed scoreboard bench for ahb_sram_ctrl with a behavioural SRAM.
module tb_ahb_sram_ctrl;
    logic        clk;
    logic        rstn;
    bit          stall;
    int          checks;
    int          errors;
    logic [31:0] ref_mem [4096];
    logic [31:0] sram    [4096];
    logic [31:0] sram_q;
    bit          inited;
    logic [31:0] exp_q [$];
    bit          pw, rd_f;
    logic [11:0] pa;
    logic [3:0]  pwen;

    ahb_sram_ctrl_if #(.AW(12)) bus ();

    ahb_sram_ctrl dut (.HCLK(clk), .HRESETn(rstn), .bus(bus.slave));

    assign bus.HREADY    = bus.HREADYOUT & ~stall;
    assign bus.SRAMRDATA = sram_q;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] init_val(input int i);
        return {i[15:0] ^ 16'hA5C3, i[15:0]};
    endfunction

    function automatic logic [3:0] lanes(input logic [2:0] sz, input logic [1:0] a);
        if (sz == 3'd0) return 4'b0001 << a;
        if (sz == 3'd1) return a[1] ? 4'b1100 : 4'b0011;
        return 4'b1111;
    endfunction

    function automatic bit in_range(input logic [31:0] a);
`ifdef AHB_SRAM_ERR_EN
        return a[13:2] < 12'd3072;
`else
        return a[13:2] == a[13:2];
`endif
    endfunction

    // synchronous SRAM: Do is valid the cycle after a read enable
    always @(posedge clk)
        if (!inited) begin
            for (int i = 0; i < 4096; i++) sram[i] <= init_val(i);
            inited <= 1'b1;
        end else if (bus.SRAMCS0) begin
            for (int k = 0; k < 4; k++)
                if (bus.SRAMWEN[k]) sram[bus.SRAMADDR][8*k +: 8] <= bus.SRAMWDATA[8*k +: 8];
            if (bus.SRAMWEN == 4'b0000) sram_q <= sram[bus.SRAMADDR];
        end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, want);
        end
    endtask

    always @(negedge clk)
        if (rstn && dut.dp_wr) chk("buf_idle_in_wr_dp", 32'(dut.buf_valid), 32'd0);

    task automatic cyc(input bit tr, input bit wr, input logic [31:0] a, input logic [2:0] sz,
                       input logic [31:0] wd, input bit rn = 1'b1, input bit st = 1'b0);
        bit          prd;
        bit          acc;
        logic [31:0] e;
        @(posedge clk);
        #1;
        rstn       = rn;
        stall      = st;
        bus.HSEL   = tr;
        bus.HTRANS = tr ? 2'b10 : 2'b00;
        bus.HWRITE = wr;
        bus.HADDR  = a;
        bus.HSIZE  = sz;
        bus.HWDATA = wd;
        if (pw && rn)
            for (int k = 0; k < 4; k++)
                if (pwen[k]) ref_mem[pa][8*k +: 8] = wd[8*k +: 8];
        prd  = rd_f;
        acc  = tr && !st && rn && in_range(a);
        pw   = acc && wr;
        rd_f = acc && !wr;
        pa   = a[13:2];
        pwen = lanes(sz, a[1:0]);
        if (rd_f) exp_q.push_back(ref_mem[a[13:2]]);
        @(negedge clk);
        if (prd) begin
            e = exp_q.pop_front();
            if (rn) chk("hrdata", bus.HRDATA, e);
        end
    endtask

    task automatic idle(input logic [31:0] wd, input bit rn = 1'b1);
        cyc(1'b0, 1'b0, 32'h0, 3'd2, wd, rn);
    endtask

    task automatic chk_port(input string tag, input logic cs, input logic [3:0] wen, input logic [11:0] addr);
        chk({tag, "_cs"}, 32'(bus.SRAMCS0), 32'(cs));
        chk({tag, "_wen"}, 32'(bus.SRAMWEN), 32'(wen));
        chk({tag, "_addr"}, 32'(bus.SRAMADDR), 32'(addr));
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rstn = 1'b0;
        stall = 1'b0;
        pw = 1'b0;
        rd_f = 1'b0;
        pa = '0;
        pwen = '0;
        bus.HSEL = 1'b0;
        bus.HADDR = '0;
        bus.HTRANS = 2'b00;
        bus.HWRITE = 1'b0;
        bus.HSIZE = 3'd2;
        bus.HWDATA = '0;
        for (int i = 0; i < 4096; i++) ref_mem[i] = init_val(i);

        idle(32'h0, 1'b0);
        idle(32'h0, 1'b0);
        chk_port("rst", 1'b0, 4'h0, 12'h0);
        chk("rst_wdata", bus.SRAMWDATA, 32'h0);
        chk("rst_ready", 32'(bus.HREADYOUT), 32'd1);
        chk("rst_resp", 32'(bus.HRESP), 32'd0);
        idle(32'h0);
        chk_port("idle", 1'b0, 4'h0, 12'h0);

        // plain write then read
        cyc(1, 1, 32'h10, 3'd2, 32'h0);
        idle(32'hDEADBEEF);
        chk_port("t1_wr", 1'b1, 4'hF, 12'd4);
        chk("t1_wdata", bus.SRAMWDATA, 32'hDEADBEEF);
        cyc(1, 0, 32'h10, 3'd2, 32'h0);
        chk_port("t1_rd", 1'b1, 4'h0, 12'd4);
        idle(32'h0);

        // write colliding with a read of the same word
        cyc(1, 1, 32'h20, 3'd2, 32'h0);
        cyc(1, 0, 32'h20, 3'd2, 32'h11223344);
        chk_port("t2_coll", 1'b1, 4'h0, 12'd8);
        idle(32'h0);
        chk_port("t2_drain", 1'b1, 4'hF, 12'd8);
        chk("t2_drain_data", bus.SRAMWDATA, 32'h11223344);
        idle(32'h0);
        chk_port("t2_after", 1'b0, 4'h0, 12'h0);

        // byte merge and halfword lanes
        cyc(1, 1, 32'h30, 3'd2, 32'h0);
        idle(32'hFFFFFFFF);
        cyc(1, 1, 32'h31, 3'd0, 32'h0);
        cyc(1, 0, 32'h30, 3'd2, 32'h0000AB00);
        cyc(1, 1, 32'h32, 3'd1, 32'h0);
        chk_port("t3_drain", 1'b1, 4'b0010, 12'd12);
        idle(32'h12340000);
        chk_port("t3_half", 1'b1, 4'b1100, 12'd12);
        cyc(1, 0, 32'h30, 3'd2, 32'h0);
        idle(32'h0);

        // buffer held across back-to-back reads
        cyc(1, 1, 32'h40, 3'd2, 32'h0);
        cyc(1, 0, 32'h44, 3'd2, 32'h40404040);
        cyc(1, 0, 32'h48, 3'd2, 32'h0);
        chk_port("t4_r48", 1'b1, 4'h0, 12'h12);
        cyc(1, 0, 32'h40, 3'd2, 32'h0);
        cyc(1, 1, 32'h4C, 3'd2, 32'h0);
        chk_port("t4_drain", 1'b1, 4'hF, 12'h10);
        chk("t4_drain_data", bus.SRAMWDATA, 32'h40404040);
        idle(32'h4C4C4C4C);
        chk_port("t4_wr4c", 1'b1, 4'hF, 12'h13);
        cyc(1, 0, 32'h40, 3'd2, 32'h0);
        idle(32'h0);

        // reset during a read data phase drops the buffered write
        cyc(1, 1, 32'h50, 3'd2, 32'h0);
        idle(32'h5A5A5A5A);
        cyc(1, 1, 32'h50, 3'd2, 32'h0);
        cyc(1, 0, 32'h50, 3'd2, 32'hCAFEF00D);
        idle(32'h0, 1'b0);
        chk_port("t5_rst", 1'b0, 4'h0, 12'h0);
        chk("t5_ready", 32'(bus.HREADYOUT), 32'd1);
        ref_mem[12'h14] = 32'h5A5A5A5A;
        idle(32'h0);
        chk_port("t5_nodrain", 1'b0, 4'h0, 12'h0);
        cyc(1, 0, 32'h50, 3'd2, 32'h0);
        idle(32'h0);

        // foreign slave stalls HREADY: no accept
        cyc(1, 0, 32'h10, 3'd2, 32'h0, 1'b1, 1'b1);
        chk_port("stall", 1'b0, 4'h0, 12'h0);
        idle(32'h0);
        chk_port("stall_after", 1'b0, 4'h0, 12'h0);

        // word index at DEPTH
        cyc(1, 0, 32'h3000, 3'd2, 32'h0);
`ifdef AHB_SRAM_ERR_EN
        chk_port("t6_ap", 1'b0, 4'h0, 12'h0);
        idle(32'h0);
        chk("t6_ready1", 32'(bus.HREADYOUT), 32'd0);
        chk("t6_resp1", 32'(bus.HRESP), 32'd1);
        chk("t6_cs1", 32'(bus.SRAMCS0), 32'd0);
        idle(32'h0);
        chk("t6_ready2", 32'(bus.HREADYOUT), 32'd1);
        chk("t6_resp2", 32'(bus.HRESP), 32'd1);
        chk("t6_cs2", 32'(bus.SRAMCS0), 32'd0);
        idle(32'h0);
        chk("t6_resp3", 32'(bus.HRESP), 32'd0);
`else
        chk_port("t6_ap", 1'b1, 4'h0, 12'hC00);
        chk("t6_resp", 32'(bus.HRESP), 32'd0);
        idle(32'h0);
        chk("t6_resp_dp", 32'(bus.HRESP), 32'd0);
        chk("t6_ready_dp", 32'(bus.HREADYOUT), 32'd1);
`endif
        idle(32'h0);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
